// File: rtl/csr_master_pkg.sv
// csr_master_pkg: shared enums for the CSR bus master.
// Op codes, response status codes and FSM states.
package csr_master_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BADOP   = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_GAP,
    S_RSP
  } state_e;

endpackage

// File: rtl/csr_bus_master.sv
// csr_bus_master: one-command-at-a-time initiator for a CSR map.
// Poll op, gap state and counters exist only with CSR_MASTER_POLL_EN.
module csr_bus_master
  import csr_master_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic              reg_clk_i,
  input  logic              reg_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [DATA_W-1:0] cmd_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [1:0]        rsp_status_o,
  output logic              busy_o,
  output logic              reg_wr_en_o,
  output logic              reg_rd_en_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wr_data_o,
  input  logic [DATA_W-1:0] reg_rd_data_i
);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cmd_ready_q, busy_q;
  logic              rsp_valid_q;
  logic              wr_en_q, rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  op_e               cmd_op;

  assign accept = cmd_valid_i & cmd_ready_q;
  assign cmd_op = op_e'(cmd_op_i);

`ifdef CSR_MASTER_POLL_EN
  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(POLL_MAX);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  op_e               op_q;
  logic [DATA_W-1:0] mask_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              match;

  // compare value is the latched write data
  assign match = ((reg_rd_data_i ^ wdata_q) & mask_q) == '0;
`else
  localparam int unused_poll_cfg = POLL_MAX + POLL_GAP;
  logic unused_mask;
  assign unused_mask = ^cmd_mask_i;
`endif

  // next-state, response data/status and poll counters
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rdata_d  = rdata_q;
`ifdef CSR_MASTER_POLL_EN
    cnt_d    = cnt_q;
    gap_d    = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rdata_d  = '0;
          status_d = ST_OK;
`ifdef CSR_MASTER_POLL_EN
          cnt_d    = '0;
`endif
          case (cmd_op)
            OP_WR: state_d = S_WR;
            OP_RD: state_d = S_RD;
`ifdef CSR_MASTER_POLL_EN
            OP_POLL: state_d = S_RD;
`endif
            default: begin
              state_d  = S_RSP;
              status_d = ST_BADOP;
            end
          endcase
        end
      end
      S_WR: state_d = S_RSP;
      S_RD: begin
        state_d = S_RD_WAIT;
`ifdef CSR_MASTER_POLL_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end
      S_RD_WAIT: begin
        rdata_d = reg_rd_data_i;
        state_d = S_RSP;
`ifdef CSR_MASTER_POLL_EN
        if (op_q == OP_POLL && !match) begin
          if (cnt_q < CNT_MAX) begin
            gap_d   = '0;
            state_d = (POLL_GAP == 0) ? S_RD : S_GAP;
          end else begin
            status_d = ST_TIMEOUT;
          end
        end
`endif
      end
      S_GAP: begin
`ifdef CSR_MASTER_POLL_EN
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = S_RD;
`else
        state_d = S_IDLE;
`endif
      end
      S_RSP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs decoded from next state
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      state_q     <= S_IDLE;
      status_q    <= ST_OK;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      rsp_valid_q <= (state_d == S_RSP);
      wr_en_q     <= (state_d == S_WR);
      rd_en_q     <= (state_d == S_RD);
    end
  end

  // command fields captured at accept
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr_i;
      wdata_q <= cmd_data_i;
    end
  end

`ifdef CSR_MASTER_POLL_EN
  // poll op, mask and counters
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      op_q   <= OP_WR;
      mask_q <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      if (accept) begin
        op_q   <= cmd_op;
        mask_q <= cmd_mask_i;
      end
    end
  end
`endif

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rdata_q;
  assign rsp_status_o  = status_q;
  assign reg_wr_en_o   = wr_en_q;
  assign reg_rd_en_o   = rd_en_q;
  assign reg_addr_o    = addr_q;
  assign reg_wr_data_o = wdata_q;

endmodule

// File: tb/tb_csr_bus_master.sv
// tb_csr_bus_master: directed bench for csr_bus_master.
// Small CSR model: addr 1 is RW with fixed high bits, others poll.
module tb_csr_bus_master;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int PMAX = 4;
  localparam int PGAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          busy;
  logic          wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rd_data = '0;

  int checks = 0;
  int failures = 0;

  csr_bus_master #(
    .ADDR_W(AW), .DATA_W(DW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)
  ) dut (
    .reg_clk_i(clk),
    .reg_rst_i(rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data),
    .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data),
    .rsp_status_o(rsp_status),
    .busy_o(busy),
    .reg_wr_en_o(wr_en),
    .reg_rd_en_o(rd_en),
    .reg_addr_o(addr),
    .reg_wr_data_o(wdata),
    .reg_rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] reg1 = '0;
  int poll_reads = 0;
  int set_at = 0;

  // CSR model: registered read data, bit 21 appears at read set_at
  always @(posedge clk) begin
    if (wr_en && addr == 8'h01) reg1 <= wdata;
    if (rd_en) begin
      if (addr == 8'h01) begin
        rd_data <= reg1 | 32'hC001_0000;
      end else begin
        rd_data <= ((set_at != 0 && poll_reads + 1 >= set_at) ?
                    32'h0020_0000 : 32'h0) |
                   32'h0000_0A00 | 32'(poll_reads[7:0]);
        poll_reads <= poll_reads + 1;
      end
    end
  end

  int wr_cnt = 0, rd_cnt = 0, overlap = 0, wr_cyc = 0;
  int rd_cyc[$];
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_cyc  <= cyc;
      wr_addr <= addr;
      wr_data <= wdata;
    end
    if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc.push_back(cyc);
    end
    if (wr_en && rd_en) overlap <= overlap + 1;
  end

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] m,
                      output int t);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    cmd_mask = m;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL accept: cmd_ready got 0 required 1 within 40");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int t, output logic [DW-1:0] d,
                          output logic [1:0] s);
    t = -1;
    d = '0;
    s = 2'b11;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        t = cyc;
        d = rsp_data;
        s = rsp_status;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL rsp_wait: rsp_valid got 0 required 1 within 40");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, busy, wr_en, rd_en, addr, wdata,
         rsp_data, rsp_status} !== '0) begin
      failures++;
      $display("FAIL reset_outs: got nonzero required all 0");
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle: got %b required 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write;
    int t, tr, w0, r0;
    logic [DW-1:0] d;
    logic [1:0] s;
    w0 = wr_cnt;
    r0 = rd_cnt;
    send(2'b00, 8'h01, 32'h0000_8015, '0, t);
    wait_rsp(tr, d, s);
    checks++;
    if (tr - t !== 2) begin
      failures++; $display("FAIL wr_lat: got %0d required 2", tr - t);
    end
    checks++;
    if ({s, d} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL wr_rsp: got %h/%h required 0/0", s, d);
    end
    checks++;
    if (wr_cnt - w0 !== 1 || rd_cnt !== r0) begin
      failures++;
      $display("FAIL wr_strobes: got wr %0d rd %0d required 1 0",
               wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if ({wr_addr, wr_data} !== {8'h01, 32'h0000_8015} ||
        wr_cyc !== t + 1) begin
      failures++;
      $display("FAIL wr_bus: got %h %h @%0d required 01 00008015 @%0d",
               wr_addr, wr_data, wr_cyc, t + 1);
    end
  endtask

  task automatic test_read;
    int t, tr, r0, w0;
    logic [DW-1:0] d;
    logic [1:0] s;
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(2'b01, 8'h01, '0, '0, t);
    wait_rsp(tr, d, s);
    checks++;
    if (tr - t !== 3) begin
      failures++; $display("FAIL rd_lat: got %0d required 3", tr - t);
    end
    checks++;
    if ({s, d} !== {2'b00, 32'hC001_8015}) begin
      failures++;
      $display("FAIL rd_rsp: got %h/%h required 0/c0018015", s, d);
    end
    checks++;
    if (rd_cnt - r0 !== 1 || wr_cnt !== w0 ||
        rd_cyc[rd_cyc.size()-1] !== t + 1) begin
      failures++;
      $display("FAIL rd_strobes: got rd %0d wr %0d required 1 0",
               rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic bad_op(input logic [1:0] op);
    int t, tr, r0, w0;
    logic [DW-1:0] d;
    logic [1:0] s;
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(op, 8'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    wait_rsp(tr, d, s);
    checks++;
    if (tr - t !== 1 || {s, d} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL bad_op%b: got lat %0d %h/%h required 1 2/0",
               op, tr - t, s, d);
    end
    checks++;
    if (rd_cnt !== r0 || wr_cnt !== w0) begin
      failures++;
      $display("FAIL bad_op_bus: got %0d strobes required 0",
               rd_cnt - r0 + wr_cnt - w0);
    end
  endtask

  task automatic test_bad_op;
    bad_op(2'b11);
`ifndef CSR_MASTER_POLL_EN
    bad_op(2'b10);
`endif
  endtask

  task automatic test_stall;
    int t, tr, n, t2;
    logic [DW-1:0] d;
    logic [1:0] s;
    rsp_ready = 1'b0;
    send(2'b01, 8'h01, '0, '0, t);
    wait_rsp(tr, d, s);
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_data, rsp_status, cmd_ready} !==
          {1'b1, 32'hC001_8015, 2'b00, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold%0d: got %b %h %b %b required 1 c0018015 00 0",
                 i, rsp_valid, rsp_data, rsp_status, cmd_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n = cyc;
    t2 = -1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) begin
        t2 = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (t2 !== n + 1) begin
      failures++;
      $display("FAIL stall_next: got accept %0d required %0d", t2, n + 1);
    end
    wait_rsp(tr, d, s);
    checks++;
    if (tr - t2 !== 1 || s !== 2'b10) begin
      failures++;
      $display("FAIL stall_rsp2: got lat %0d st %b required 1 10",
               tr - t2, s);
    end
  endtask

  task automatic b2b(input logic [1:0] op, input int gap);
    int acc[2];
    int n;
    n = 0;
    acc[0] = 0;
    acc[1] = -100;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = 8'h01;
    cmd_data = 32'h0000_8015;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        acc[n] = cyc;
        n++;
        if (n == 2) break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (acc[1] - acc[0] !== gap) begin
      failures++;
      $display("FAIL b2b_op%b: got spacing %0d required %0d",
               op, acc[1] - acc[0], gap);
    end
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_drain: got %b required 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_back_to_back;
    b2b(2'b00, 3);
    b2b(2'b01, 4);
  endtask

`ifdef CSR_MASTER_POLL_EN
  task automatic test_poll;
    int t, tr, q0, base;
    logic [DW-1:0] d;
    logic [1:0] s;
    base = poll_reads;
    set_at = base + 3;
    q0 = rd_cyc.size();
    send(2'b10, 8'h00, 32'h0020_0000, 32'h0020_0000, t);
    wait_rsp(tr, d, s);
    set_at = 0;
    checks++;
    if (rd_cyc.size() - q0 !== 3) begin
      failures++;
      $display("FAIL poll_reads: got %0d required 3", rd_cyc.size() - q0);
    end else begin
      checks++;
      if (rd_cyc[q0] !== t + 1 ||
          rd_cyc[q0+1] - rd_cyc[q0] !== PGAP + 2 ||
          rd_cyc[q0+2] - rd_cyc[q0+1] !== PGAP + 2) begin
        failures++;
        $display("FAIL poll_space: got %0d %0d %0d required %0d +%0d +%0d",
                 rd_cyc[q0], rd_cyc[q0+1], rd_cyc[q0+2], t + 1,
                 PGAP + 2, PGAP + 2);
      end
    end
    checks++;
    if ({s, d} !== {2'b00, 32'h0020_0A00 | 32'(base + 2)} ||
        tr - t !== 11) begin
      failures++;
      $display("FAIL poll_rsp: got %b/%h lat %0d required 00/%h 11",
               s, d, tr - t, 32'h0020_0A00 | 32'(base + 2));
    end
  endtask

  task automatic test_timeout;
    int t, tr, q0, base;
    logic [DW-1:0] d;
    logic [1:0] s;
    base = poll_reads;
    set_at = 0;
    q0 = rd_cyc.size();
    send(2'b10, 8'h00, 32'h0020_0000, 32'h0020_0000, t);
    wait_rsp(tr, d, s);
    checks++;
    if (rd_cyc.size() - q0 !== PMAX) begin
      failures++;
      $display("FAIL to_reads: got %0d required %0d",
               rd_cyc.size() - q0, PMAX);
    end
    checks++;
    if ({s, d} !== {2'b01, 32'h0000_0A00 | 32'(base + 3)} ||
        tr - t !== 15) begin
      failures++;
      $display("FAIL to_rsp: got %b/%h lat %0d required 01/%h 15",
               s, d, tr - t, 32'h0000_0A00 | 32'(base + 3));
    end
  endtask
`endif

  task automatic reset_mid(input logic [1:0] op, input int dly);
    int t, seen;
    send(op, 8'h00, 32'h0020_0000, 32'h0020_0000, t);
    repeat (dly) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || (dly == 0 && rd_en !== 1'b1)) begin
      failures++;
      $display("FAIL rstmid_pre%b: got busy %b rd %b required 1",
               op, busy, rd_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, rd_en, rsp_valid, busy, cmd_ready} !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_drop%b: got %b required 00000", op,
               {wr_en, rd_en, rsp_valid, busy, cmd_ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || {cmd_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_post%b: got rsp %0d rdy/busy %b required 0 10",
               op, seen, {cmd_ready, busy});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_op();
    test_stall();
    test_back_to_back();
`ifdef CSR_MASTER_POLL_EN
    test_poll();
    test_timeout();
    reset_mid(2'b10, 2);
`endif
    reset_mid(2'b01, 0);
    test_read();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL overlap: got %0d required 0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
